// File: rtl/mrd_rdx_twdl_stage.sv
// ============================================================================
// Module      : mrd_rdx_twdl_stage
// Description : Mixed-radix twiddle stage. Five complex lanes, per-beat ROM
//               address walk, Q1.(wTw-2) rotate with rounding, 4-cycle latency.
//               Optional macro MRD_TWDL_SAT_EN: saturate instead of wrap.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mrd_rdx_twdl_stage #(
    parameter int wData     = 30,
    parameter int wTw       = 16,
    parameter int wAddr     = 12,
    parameter int wBankAddr = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_i,
    input  logic [2:0]                      cfg_radix_i,
    input  logic [wAddr-1:0]                cfg_step_i,
    input  logic [wAddr-1:0]                cfg_ceil_i,
    input  logic [11:0]                     cfg_time_i,
    input  logic                            in_val_i,
    input  logic [0:4][wData-1:0]           din_real_i,
    input  logic [0:4][wData-1:0]           din_imag_i,
    input  logic [0:4][2:0]                 in_bank_index_i,
    input  logic [0:4][wBankAddr-1:0]       in_bank_addr_i,
    output logic [0:4][wAddr-1:0]           tw_rom_addr_o,
    input  logic [0:4][wTw-1:0]             tw_rom_real_i,
    input  logic [0:4][wTw-1:0]             tw_rom_imag_i,
    output logic                            out_val_o,
    output logic [0:4][wData-1:0]           dout_real_o,
    output logic [0:4][wData-1:0]           dout_imag_o,
    output logic [0:4][2:0]                 out_bank_index_o,
    output logic [0:4][wBankAddr-1:0]       out_bank_addr_o,
    output logic                            busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int c_lanes = 5;
    localparam int c_wp    = wData + wTw + 1;
    localparam int c_shift = wTw - 2;
    localparam logic signed [c_wp-1:0] c_rnd = {{(c_wp-1){1'b0}}, 1'b1} << (wTw - 3);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [11:0]        cnt_q, cnt_d;
    logic [wAddr-1:0]   base_q, base_d;
    logic [wAddr-1:0]   step_q, step_d;
    logic [wAddr-1:0]   ceil_q, ceil_d;
    logic [11:0]        time_q, time_d;
    logic [2:0]         radix_q, radix_d;

    // Effective values for the current beat: a coincident start overrides.
    logic               w_run;
    logic [11:0]        w_cnt;
    logic [wAddr-1:0]   w_base;
    logic [wAddr-1:0]   w_step;
    logic [wAddr-1:0]   w_ceil;
    logic [11:0]        w_time;
    logic [2:0]         w_radix;
    logic [wAddr:0]     w_base_sum;
    logic [wAddr-1:0]   w_base_next;

    assign w_run       = start_i || (state_q == ST_RUN);
    assign w_cnt       = start_i ? 12'd0 : cnt_q;
    assign w_base      = (state_q == ST_RUN && !start_i) ? base_q : '0;
    assign w_step      = start_i ? cfg_step_i : step_q;
    assign w_ceil      = start_i ? cfg_ceil_i : ceil_q;
    assign w_time      = start_i ? cfg_time_i : time_q;
    assign w_radix     = start_i ? cfg_radix_i : ((state_q == ST_RUN) ? radix_q : 3'd5);
    assign w_base_sum  = {1'b0, w_base} + {1'b0, w_step};
    assign w_base_next = (w_base_sum >= {1'b0, w_ceil}) ? (w_base_sum[wAddr-1:0] - w_ceil)
                                                        : w_base_sum[wAddr-1:0];
    assign busy_o      = (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        step_d  = step_q;
        ceil_d  = ceil_q;
        time_d  = time_q;
        radix_d = radix_q;
        if (start_i) begin
            state_d = ST_RUN;
            radix_d = cfg_radix_i;
            step_d  = cfg_step_i;
            ceil_d  = cfg_ceil_i;
            time_d  = cfg_time_i;
            cnt_d   = '0;
            base_d  = '0;
        end
        if (in_val_i && w_run) begin
            if (w_cnt == (w_time - 12'd1)) begin
                cnt_d  = '0;
                base_d = w_base_next;
            end else begin
                cnt_d  = w_cnt + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            step_q  <= '0;
            ceil_q  <= '0;
            time_q  <= '0;
            radix_q <= 3'd5;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            step_q  <= step_d;
            ceil_q  <= ceil_d;
            time_q  <= time_d;
            radix_q <= radix_d;
        end
    end

    // ------------------------------------------------------------------
    // Lane addresses k*base mod ceil, built by chained modular adds
    // ------------------------------------------------------------------
    logic [0:4][wAddr-1:0] w_lane_addr;
    logic [wAddr-1:0]      w_acc;
    logic [wAddr:0]        w_sum;
    logic [c_lanes-1:0]    w_mask;

    always_comb begin
        w_lane_addr = '0;
        w_acc       = '0;
        w_sum       = '0;
        for (int k = 1; k < c_lanes; k++) begin
            w_sum = {1'b0, w_acc} + {1'b0, w_base};
            if (w_sum >= {1'b0, w_ceil}) begin
                w_acc = w_sum[wAddr-1:0] - w_ceil;
            end else begin
                w_acc = w_sum[wAddr-1:0];
            end
            w_lane_addr[k] = w_acc;
        end
    end

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < c_lanes; k++) begin
            w_mask[k] = (3'(k) < w_radix);
        end
    end

    // ------------------------------------------------------------------
    // Pipeline: s1 (ROM address out), s2 (ROM data back), s3 (products), out
    // ------------------------------------------------------------------
    logic                           s1_val_q, s2_val_q, s3_val_q;
    logic [0:4][wData-1:0]          s1_re_q, s1_im_q, s2_re_q, s2_im_q;
    logic [0:4][2:0]                s1_bidx_q, s2_bidx_q, s3_bidx_q;
    logic [0:4][wBankAddr-1:0]      s1_badr_q, s2_badr_q, s3_badr_q;
    logic [c_lanes-1:0]             s1_mask_q, s2_mask_q, s3_mask_q;
    logic [0:4][c_wp-1:0]           s3_pre_q, s3_pim_q;
    logic [0:4][c_wp-1:0]           w_pre, w_pim;
    logic [0:4][wData-1:0]          w_fit_re, w_fit_im;

    for (genvar k = 0; k < c_lanes; k++) begin : g_lane
        logic signed [c_wp-1:0] w_dr, w_di, w_wr, w_wi;
        logic signed [c_wp-1:0] w_sre, w_sim, w_rre, w_rim;
        logic                   w_unused_hi;

        assign w_dr = {{(c_wp-wData){s2_re_q[k][wData-1]}}, s2_re_q[k]};
        assign w_di = {{(c_wp-wData){s2_im_q[k][wData-1]}}, s2_im_q[k]};
        assign w_wr = {{(c_wp-wTw){tw_rom_real_i[k][wTw-1]}}, tw_rom_real_i[k]};
        assign w_wi = {{(c_wp-wTw){tw_rom_imag_i[k][wTw-1]}}, tw_rom_imag_i[k]};

        assign w_pre[k] = w_dr * w_wr - w_di * w_wi;
        assign w_pim[k] = w_dr * w_wi + w_di * w_wr;

        // Round half up, then drop the Q1.(wTw-2) fraction.
        assign w_sre = s3_pre_q[k] + c_rnd;
        assign w_sim = s3_pim_q[k] + c_rnd;
        assign w_rre = w_sre >>> c_shift;
        assign w_rim = w_sim >>> c_shift;
        assign w_unused_hi = ^{w_rre[c_wp-1:wData], w_rim[c_wp-1:wData]};

`ifdef MRD_TWDL_SAT_EN
        localparam logic [wData-1:0] c_max = {1'b0, {(wData-1){1'b1}}};
        localparam logic [wData-1:0] c_min = {1'b1, {(wData-1){1'b0}}};
        logic w_ovf_re, w_ovf_im;
        assign w_ovf_re = !((&w_rre[c_wp-1:wData-1]) || !(|w_rre[c_wp-1:wData-1]));
        assign w_ovf_im = !((&w_rim[c_wp-1:wData-1]) || !(|w_rim[c_wp-1:wData-1]));
        assign w_fit_re[k] = w_ovf_re ? (w_rre[c_wp-1] ? c_min : c_max) : w_rre[wData-1:0];
        assign w_fit_im[k] = w_ovf_im ? (w_rim[c_wp-1] ? c_min : c_max) : w_rim[wData-1:0];
`else
        assign w_fit_re[k] = w_rre[wData-1:0];
        assign w_fit_im[k] = w_rim[wData-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tw_rom_addr_o    <= '0;
            s1_val_q         <= 1'b0;
            s1_re_q          <= '0;
            s1_im_q          <= '0;
            s1_bidx_q        <= '0;
            s1_badr_q        <= '0;
            s1_mask_q        <= '0;
            s2_val_q         <= 1'b0;
            s2_re_q          <= '0;
            s2_im_q          <= '0;
            s2_bidx_q        <= '0;
            s2_badr_q        <= '0;
            s2_mask_q        <= '0;
            s3_val_q         <= 1'b0;
            s3_pre_q         <= '0;
            s3_pim_q         <= '0;
            s3_bidx_q        <= '0;
            s3_badr_q        <= '0;
            s3_mask_q        <= '0;
            out_val_o        <= 1'b0;
            dout_real_o      <= '0;
            dout_imag_o      <= '0;
            out_bank_index_o <= '0;
            out_bank_addr_o  <= '0;
        end else begin
            if (in_val_i) begin
                tw_rom_addr_o <= w_lane_addr;
            end
            s1_val_q  <= in_val_i;
            s1_re_q   <= din_real_i;
            s1_im_q   <= din_imag_i;
            s1_bidx_q <= in_bank_index_i;
            s1_badr_q <= in_bank_addr_i;
            s1_mask_q <= w_mask;

            s2_val_q  <= s1_val_q;
            s2_re_q   <= s1_re_q;
            s2_im_q   <= s1_im_q;
            s2_bidx_q <= s1_bidx_q;
            s2_badr_q <= s1_badr_q;
            s2_mask_q <= s1_mask_q;

            s3_val_q  <= s2_val_q;
            s3_pre_q  <= w_pre;
            s3_pim_q  <= w_pim;
            s3_bidx_q <= s2_bidx_q;
            s3_badr_q <= s2_badr_q;
            s3_mask_q <= s2_mask_q;

            out_val_o        <= s3_val_q;
            out_bank_index_o <= s3_bidx_q;
            out_bank_addr_o  <= s3_badr_q;
            for (int k = 0; k < c_lanes; k++) begin
                dout_real_o[k] <= s3_mask_q[k] ? w_fit_re[k] : '0;
                dout_imag_o[k] <= s3_mask_q[k] ? w_fit_im[k] : '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mrd_rdx_twdl_stage.sv
// ============================================================================
// Module      : tb_mrd_rdx_twdl_stage
// Description : Scoreboard bench for mrd_rdx_twdl_stage with a registered ROM model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mrd_rdx_twdl_stage;

    localparam int WD = 30;
    localparam int WT = 16;
    localparam int WA = 12;
    localparam int WB = 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [2:0]             cfg_radix = 3'd5;
    logic [WA-1:0]          cfg_step = '0;
    logic [WA-1:0]          cfg_ceil = 12'd1;
    logic [11:0]            cfg_time = 12'd1;
    logic                   in_val = 1'b0;
    logic [0:4][WD-1:0]     din_real = '0;
    logic [0:4][WD-1:0]     din_imag = '0;
    logic [0:4][2:0]        in_bank_index = '0;
    logic [0:4][WB-1:0]     in_bank_addr = '0;
    logic [0:4][WA-1:0]     tw_rom_addr;
    logic [0:4][WT-1:0]     tw_rom_real = '0;
    logic [0:4][WT-1:0]     tw_rom_imag = '0;
    logic                   out_val;
    logic [0:4][WD-1:0]     dout_real;
    logic [0:4][WD-1:0]     dout_imag;
    logic [0:4][2:0]        out_bank_index;
    logic [0:4][WB-1:0]     out_bank_addr;
    logic                   busy;

    always #5 clk = ~clk;

    mrd_rdx_twdl_stage #(
        .wData(WD), .wTw(WT), .wAddr(WA), .wBankAddr(WB)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start),
        .cfg_radix_i      (cfg_radix),
        .cfg_step_i       (cfg_step),
        .cfg_ceil_i       (cfg_ceil),
        .cfg_time_i       (cfg_time),
        .in_val_i         (in_val),
        .din_real_i       (din_real),
        .din_imag_i       (din_imag),
        .in_bank_index_i  (in_bank_index),
        .in_bank_addr_i   (in_bank_addr),
        .tw_rom_addr_o    (tw_rom_addr),
        .tw_rom_real_i    (tw_rom_real),
        .tw_rom_imag_i    (tw_rom_imag),
        .out_val_o        (out_val),
        .dout_real_o      (dout_real),
        .dout_imag_o      (dout_imag),
        .out_bank_index_o (out_bank_index),
        .out_bank_addr_o  (out_bank_addr),
        .busy_o           (busy)
    );

    // ROM model: mode 0 = 1.0, 1 = -j, 2 = ~2.0, 3 = address dependent
    int rom_mode = 3;

    function automatic int rom_re(input int m, input int a);
        case (m)
            0:       return 16384;
            1:       return 0;
            2:       return 32767;
            default: return 16384 - 9 * a;
        endcase
    endfunction

    function automatic int rom_im(input int m, input int a);
        case (m)
            0:       return 0;
            1:       return -16384;
            2:       return 0;
            default: return 3 * a - 200;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 5; k++) begin
            tw_rom_real[k] <= WT'(rom_re(rom_mode, int'(tw_rom_addr[k])));
            tw_rom_imag[k] <= WT'(rom_im(rom_mode, int'(tw_rom_addr[k])));
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WD-1:0] fit(input longint v);
        longint r;
        r = (v + 64'sd8192) >>> 14;
`ifdef MRD_TWDL_SAT_EN
        if (r > 64'sd536870911)       r = 64'sd536870911;
        else if (r < -64'sd536870912) r = -64'sd536870912;
`endif
        return r[WD-1:0];
    endfunction

    function automatic logic [WD-1:0] rand30();
        int x;
        x = int'($urandom_range(0, 2097151)) - 1048576;
        return x[WD-1:0];
    endfunction

    typedef struct {
        logic [0:4][WD-1:0] re;
        logic [0:4][WD-1:0] im;
        logic [0:4][2:0]    bi;
        logic [0:4][WB-1:0] ba;
    } exp_t;
    typedef logic [0:4][WA-1:0] addr_t;

    exp_t  sb[$];
    addr_t aq[$];

    // Reference frame model
    bit m_run = 1'b0;
    int m_radix, m_step, m_ceil, m_time, m_base, m_cnt;
    bit rnd_data = 1'b1;
    bit rnd_sb   = 1'b1;

    task automatic beat(input bit st, input bit v);
        exp_t   e;
        addr_t  a;
        int     rad, bb, wr, wi;
        longint dr, di;
        @(negedge clk);
        start  = st;
        in_val = v;
        if (v && rnd_data) begin
            for (int k = 0; k < 5; k++) begin
                din_real[k] = rand30();
                din_imag[k] = rand30();
            end
        end
        if (v && rnd_sb) begin
            for (int k = 0; k < 5; k++) begin
                in_bank_index[k] = 3'($urandom_range(0, 7));
                in_bank_addr[k]  = WB'($urandom_range(0, 255));
            end
        end
        if (st) begin
            m_run = 1'b1;
            m_radix = int'(cfg_radix);
            m_step = int'(cfg_step);
            m_ceil = int'(cfg_ceil);
            m_time = int'(cfg_time);
            m_base = 0;
            m_cnt = 0;
        end
        if (v) begin
            bb  = m_run ? m_base : 0;
            rad = m_run ? m_radix : 5;
            for (int k = 0; k < 5; k++) begin
                a[k] = m_run ? WA'((k * bb) % m_ceil) : '0;
                wr = rom_re(rom_mode, int'(a[k]));
                wi = rom_im(rom_mode, int'(a[k]));
                dr = longint'($signed(din_real[k]));
                di = longint'($signed(din_imag[k]));
                e.re[k] = (k < rad) ? fit(dr * wr - di * wi) : '0;
                e.im[k] = (k < rad) ? fit(dr * wi + di * wr) : '0;
                e.bi[k] = in_bank_index[k];
                e.ba[k] = in_bank_addr[k];
            end
            sb.push_back(e);
            aq.push_back(a);
            if (m_run) begin
                if (m_cnt == m_time - 1) begin
                    m_cnt  = 0;
                    m_base = (m_base + m_step) % m_ceil;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0);
    endtask

    task automatic set_cfg(input int r, input int s, input int c, input int t);
        cfg_radix = 3'(r);
        cfg_step  = WA'(s);
        cfg_ceil  = WA'(c);
        cfg_time  = 12'(t);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rst_tw_addr%0d", k), 64'(tw_rom_addr[k]), 64'd0);
            chk($sformatf("rst_dout_re%0d", k), 64'(dout_real[k]), 64'd0);
            chk($sformatf("rst_bank_idx%0d", k), 64'(out_bank_index[k]), 64'd0);
        end
    endtask

    // Expected latency shift: out_val must follow in_val by exactly 4 cycles.
    logic [3:0] vsh;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsh <= '0;
        else        vsh <= {vsh[2:0], in_val};
    end

    addr_t m_a;
    exp_t  m_e;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_val", 64'(out_val), 64'(vsh[3]));
            if (vsh[0]) begin
                chk("addr_q_nonempty", 64'(aq.size() != 0), 64'd1);
                if (aq.size() != 0) begin
                    m_a = aq.pop_front();
                    for (int k = 0; k < 5; k++)
                        chk($sformatf("tw_addr%0d", k), 64'(tw_rom_addr[k]), 64'(m_a[k]));
                end
            end
            if (out_val) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    m_e = sb.pop_front();
                    for (int k = 0; k < 5; k++) begin
                        chk($sformatf("dout_re%0d", k), 64'(dout_real[k]), 64'(m_e.re[k]));
                        chk($sformatf("dout_im%0d", k), 64'(dout_imag[k]), 64'(m_e.im[k]));
                        chk($sformatf("bank_idx%0d", k), 64'(out_bank_index[k]), 64'(m_e.bi[k]));
                        chk($sformatf("bank_addr%0d", k), 64'(out_bank_addr[k]), 64'(m_e.ba[k]));
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Pass-through while idle: all lanes, twiddle at address 0
        rom_mode = 3;
        repeat (3) beat(1'b0, 1'b1);
        idle(1);
        chk("idle_busy", 64'(busy), 64'd0);
        idle(5);

        // Identity rotation with radix 4
        rom_mode = 0;
        set_cfg(4, 0, 1024, 1);
        rnd_data = 1'b0;
        for (int k = 0; k < 5; k++) begin
            din_real[k] = WD'(1000);
            din_imag[k] = '0;
        end
        beat(1'b1, 1'b1);
        repeat (2) beat(1'b0, 1'b1);
        idle(1);
        chk("run_busy", 64'(busy), 64'd1);
        idle(5);

        // Address walk, radix 5, step 3, modulus 16, two beats per step
        rom_mode = 3;
        rnd_data = 1'b1;
        set_cfg(5, 3, 16, 2);
        beat(1'b1, 1'b0);
        repeat (6) beat(1'b0, 1'b1);
        idle(5);

        // Rotation by -j
        rom_mode = 1;
        rnd_data = 1'b0;
        set_cfg(5, 1, 8, 1);
        for (int k = 0; k < 5; k++) begin
            din_real[k] = WD'(500);
            din_imag[k] = WD'(200);
        end
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b1);
        idle(5);

        // Overflow at ~2.0 gain, both signs
        rom_mode = 2;
        for (int k = 0; k < 5; k++) begin
            din_real[k] = (k % 2 == 0) ? WD'(536870911) : WD'(-536870912);
            din_imag[k] = WD'(-(k * 1000));
        end
        repeat (2) beat(1'b0, 1'b1);
        idle(5);

        // Fixed sideband pattern with gapped traffic
        rom_mode = 3;
        rnd_data = 1'b1;
        rnd_sb = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_bank_index[k] = 3'(k);
            in_bank_addr[k]  = 8'h55;
        end
        for (int i = 0; i < 10; i++) beat(1'b0, 1'($urandom_range(0, 1)));
        rnd_sb = 1'b1;
        idle(5);

        // Restart while beats are in flight
        set_cfg(5, 5, 32, 1);
        beat(1'b1, 1'b1);
        repeat (3) beat(1'b0, 1'b1);
        set_cfg(3, 7, 32, 1);
        beat(1'b1, 1'b1);
        repeat (3) beat(1'b0, 1'b1);
        idle(5);

        // Reset mid-stream
        set_cfg(5, 2, 16, 1);
        beat(1'b1, 1'b1);
        repeat (2) beat(1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        start  = 1'b0;
        in_val = 1'b0;
        sb.delete();
        aq.delete();
        m_run = 1'b0;
        m_base = 0;
        m_cnt = 0;
        #1;
        chk_reset_outputs();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        idle(6);
        chk("post_rst_busy", 64'(busy), 64'd0);
        repeat (2) beat(1'b0, 1'b1);
        idle(6);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("aq_drained", 64'(aq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mrd_rdx_twdl_stage.md
MRD_RDX_TWDL_STAGE -- requirements
Module: mrd_rdx_twdl_stage

Interface
REQ-001 Parameter wData, default 30, lane data width (signed, real and imag).
REQ-002 Parameter wTw, default 16, twiddle width, signed Q1.(wTw-2), 1.0 = 2^(wTw-2).
REQ-003 Parameter wAddr, default 12, twiddle ROM address/exponent width.
REQ-004 Parameter wBankAddr, default 8, sideband bank address width.
REQ-005 clk  in  1  single clock; rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse, latches cfg_*, begins frame.
REQ-007 cfg_radix in 3 (2..5, active lanes); cfg_step in wAddr; cfg_ceil in wAddr (modulus, >0); cfg_time in 12 (beats per exponent step, >0).
REQ-008 in_val in 1; din_real, din_imag in [0:4][wData]; in_bank_index in [0:4][3]; in_bank_addr in [0:4][wBankAddr].
REQ-009 tw_rom_addr out [0:4][wAddr]; tw_rom_real, tw_rom_imag in [0:4][wTw], valid exactly 1 cycle after address.
REQ-010 out_val out 1; dout_real, dout_imag out [0:4][wData]; out_bank_index out [0:4][3]; out_bank_addr out [0:4][wBankAddr]; busy out 1.

Function
REQ-011 States IDLE, RUN; start in any state -> RUN, clears counters, latches cfg; busy=1 in RUN.
REQ-012 In RUN each in_val beat increments time_cnt; at time_cnt==cfg_time-1 it wraps to 0 and base <= (base+cfg_step) mod cfg_ceil (single conditional subtract).
REQ-013 Lane k address = k*base mod cfg_ceil, built as chained add-and-conditional-subtract from lane k-1; lane 0 address 0.
REQ-014 Addresses registered to tw_rom_addr on the cycle after the in_val beat; data/sideband delayed in step.
REQ-015 Fixed latency 4 cycles in_val -> out_val, no backpressure, one beat per cycle sustained.
REQ-016 Complex multiply full precision, then add 2^(wTw-3) and arithmetic shift right wTw-2.
REQ-017 Lanes k >= cfg_radix output dout 0; sideband still passed.
REQ-018 out_bank_index/out_bank_addr equal inputs of the same beat, delayed 4 cycles, all lanes.
REQ-019 in_val while IDLE: data passed with base=0 (all twiddles at addr 0), counters frozen.
REQ-020 start coincident with in_val: that beat uses new cfg and counters at 0.
REQ-021 Beats already in pipeline when start arrives complete with their original twiddles.
REQ-022 RUN -> IDLE never automatically; only reset returns to IDLE.

Reset
REQ-023 rst_n low: state IDLE, counters/base 0, out_val 0, busy 0, tw_rom_addr 0, dout/sideband 0.
REQ-024 Reset mid-frame discards all pipeline beats; no out_val until 4 cycles after next in_val.

Configuration
REQ-025 Macro MRD_TWDL_SAT_EN defined: rounded result outside wData range saturates to +(2^(wData-1)-1) or -2^(wData-1).
REQ-026 Macro MRD_TWDL_SAT_EN undefined: rounded result truncated to low wData bits (two's-complement wrap).

Verification
REQ-027 Identity: start radix=4, step=0, ceil=1024, time=1; ROM returns 2^14 real, 0 imag; din_real=1000 lanes -> dout_real=1000 lanes 0..3, lane 4 = 0, out_val 4 cycles after in_val.
REQ-028 Address walk: radix=5, step=3, ceil=16, time=2, 6 beats -> base 0,0,3,3,6,6; lane 4 addresses beat 3 = 12, beat 5 = 24 mod 16 = 8.
REQ-029 Rotation: twiddle -j (0, -2^14), din=(500,200) -> dout=(200,-500).
REQ-030 Overflow: din_real=2^29-1, twiddle real 2^14+... use tw=(2^15-1)/Q -> with MRD_TWDL_SAT_EN dout=2^29-1; without, wrapped negative value.
REQ-031 Sideband/reset: bank_index 0..4, bank_addr 0x55 random beats -> identical at output +4 cycles; rst_n low mid-stream -> out_val 0 immediately, no stale beats after release.
REQ-032 Restart: start during RUN coincident with in_val -> that beat base 0, preceding in-flight beats unaffected.
